// File: rtl/msk_tx_scheduler.sv
// msk_tx_scheduler: shares one MSK modulator between two byte requesters,
// round-robin per frame, with a preamble and a modulator reset before each byte.
module msk_tx_scheduler #(
   parameter int                    DATA_WIDTH      = 8,
   parameter int                    SAMPLES_PER_BIT = 32,
   parameter int                    PREAMBLE_LEN    = 2,
   parameter logic [DATA_WIDTH-1:0] PREAMBLE_BYTE   = DATA_WIDTH'(8'h55)
) (
   input  logic                  G_CLK_TX,
   input  logic                  reset,
   input  logic                  abort,
   input  logic [1:0]            req_valid,
   input  logic [DATA_WIDTH-1:0] req_data0,
   input  logic [DATA_WIDTH-1:0] req_data1,
   input  logic [1:0]            req_last,
   output logic [1:0]            req_ready,
   output logic [DATA_WIDTH-1:0] mod_data,
   output logic                  mod_enable,
   output logic                  mod_rst_n,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  underrun
);

   localparam int BYTE_CYCLES = DATA_WIDTH * SAMPLES_PER_BIT;
   localparam int CNT_W       = $clog2(BYTE_CYCLES) + 1;
   localparam int PRE_W       = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYCLES - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRE_LOAD = 3'd1;
   localparam logic [2:0] S_PRE_SEND = 3'd2;
   localparam logic [2:0] S_DAT_LOAD = 3'd3;
   localparam logic [2:0] S_DAT_SEND = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
   logic                  last_q, last_d;
   logic                  und_seen_q, und_seen_d;
   logic                  last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0] mod_data_q, mod_data_d;
   logic                  mod_enable_q, mod_enable_d;
   logic                  mod_rst_n_q, mod_rst_n_d;
   logic [1:0]            grant_q, grant_d;
   logic                  busy_q, busy_d;
   logic                  frame_done_q, frame_done_d;
   logic                  underrun_q, underrun_d;

   logic                  own_valid;
   logic                  own_last;
   logic [DATA_WIDTH-1:0] own_data;
   logic                  byte_end;
   logic                  pick;
   logic                  send_d;

   assign own_valid = |(req_valid & grant_q);
   assign own_last  = |(req_last & grant_q);
   assign own_data  = grant_q[1] ? req_data1 : req_data0;
   assign byte_end  = (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      pre_cnt_d    = pre_cnt_q;
      last_d       = last_q;
      last_grant_d = last_grant_q;
      mod_data_d   = mod_data_q;
      grant_d      = grant_q;
      underrun_d   = 1'b0;
      pick         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            pre_cnt_d = '0;
            if (|req_valid) begin
               pick         = (&req_valid) ? ~last_grant_q : req_valid[1];
               grant_d      = pick ? 2'b10 : 2'b01;
               last_grant_d = pick;
               state_d      = (PREAMBLE_LEN == 0) ? S_DAT_LOAD : S_PRE_LOAD;
            end
         end
         S_PRE_LOAD: state_d = S_PRE_SEND;
         S_PRE_SEND: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (byte_end) begin
               cnt_d     = '0;
               pre_cnt_d = pre_cnt_q + PRE_W'(1);
               state_d   = (int'(pre_cnt_q) + 1 < PREAMBLE_LEN) ?
                           S_PRE_LOAD : S_DAT_LOAD;
            end
         end
         S_DAT_LOAD: begin
            if (own_valid) begin
               mod_data_d = own_data;
               last_d     = own_last;
               state_d    = S_DAT_SEND;
            end else if (!und_seen_q) begin
               underrun_d = 1'b1;
            end
         end
         S_DAT_SEND: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (byte_end) begin
               cnt_d   = '0;
               state_d = last_q ? S_DONE : S_DAT_LOAD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // abort wins over every transition, including a load in flight
      if (abort && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         underrun_d = 1'b0;
         mod_data_d = mod_data_q;
         last_d     = last_q;
      end

      if (state_d == S_PRE_LOAD) mod_data_d = PREAMBLE_BYTE;
      if (state_d == S_IDLE || state_d == S_DONE) grant_d = 2'b00;

      send_d       = (state_d == S_PRE_SEND) || (state_d == S_DAT_SEND);
      und_seen_d   = (state_d == S_DAT_LOAD) && (und_seen_q || underrun_d);
      mod_enable_d = send_d;
      mod_rst_n_d  = send_d;
      busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
      frame_done_d = (state_d == S_DONE);
   end

   always_ff @(posedge G_CLK_TX or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         pre_cnt_q    <= '0;
         last_q       <= 1'b0;
         und_seen_q   <= 1'b0;
         last_grant_q <= 1'b1;
         mod_data_q   <= '0;
         mod_enable_q <= 1'b0;
         mod_rst_n_q  <= 1'b0;
         grant_q      <= 2'b00;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pre_cnt_q    <= pre_cnt_d;
         last_q       <= last_d;
         und_seen_q   <= und_seen_d;
         last_grant_q <= last_grant_d;
         mod_data_q   <= mod_data_d;
         mod_enable_q <= mod_enable_d;
         mod_rst_n_q  <= mod_rst_n_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign req_ready  = (state_q == S_DAT_LOAD) ? grant_q : 2'b00;
   assign mod_data   = mod_data_q;
   assign mod_enable = mod_enable_q;
   assign mod_rst_n  = mod_rst_n_q;
   assign grant      = grant_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_msk_tx_scheduler.sv
// tb_msk_tx_scheduler: directed scenarios for the two-requester MSK scheduler,
// including a second instance with no preamble and short bytes.
module tb_msk_tx_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       abort;
   logic [1:0] req_valid, req_last, req_ready, grant;
   logic [7:0] req_data0, req_data1, mod_data;
   logic       mod_enable, mod_rst_n, busy, frame_done, underrun;

   logic       b_abort;
   logic [1:0] b_valid, b_last, b_ready, b_grant;
   logic [7:0] b_data0, b_data1, b_mod_data;
   logic       b_enable, b_rst_n, b_busy, b_frame_done, b_underrun;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   msk_tx_scheduler u_dut (
      .G_CLK_TX   (clk),
      .reset      (rst_n),
      .abort      (abort),
      .req_valid  (req_valid),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .mod_data   (mod_data),
      .mod_enable (mod_enable),
      .mod_rst_n  (mod_rst_n),
      .grant      (grant),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   msk_tx_scheduler #(
      .PREAMBLE_LEN    (0),
      .SAMPLES_PER_BIT (4)
   ) u_dut2 (
      .G_CLK_TX   (clk),
      .reset      (rst_n),
      .abort      (b_abort),
      .req_valid  (b_valid),
      .req_data0  (b_data0),
      .req_data1  (b_data1),
      .req_last   (b_last),
      .req_ready  (b_ready),
      .mod_data   (b_mod_data),
      .mod_enable (b_enable),
      .mod_rst_n  (b_rst_n),
      .grant      (b_grant),
      .busy       (b_busy),
      .frame_done (b_frame_done),
      .underrun   (b_underrun)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; abort = 1'b0;
      req_valid = 2'b00; req_last = 2'b00;
      req_data0 = 8'h00; req_data1 = 8'h00;
      b_abort = 1'b0; b_valid = 2'b00; b_last = 2'b00;
      b_data0 = 8'h00; b_data1 = 8'h00;
      tick(); tick();
      tests++;
      if ({mod_data, mod_enable, mod_rst_n, req_ready, grant,
           busy, frame_done, underrun} !== 17'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h/%b/%b/%b/%b/%b/%b/%b want 0",
                  mod_data, mod_enable, mod_rst_n, req_ready, grant,
                  busy, frame_done, underrun);
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if ({busy, grant, mod_enable} !== 4'b0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b grant=%b en=%b want 0",
                  busy, grant, mod_enable);
      end
   endtask

   task automatic test_single_frame;
      logic [7:0] exp_seq [4];
      logic [7:0] held;
      logic       hs;
      int cyc, run, seg, rdy, done_at, bad, first_en, bi;
      exp_seq = '{8'h55, 8'h55, 8'hA5, 8'h3C};
      cyc = 0; run = 0; seg = 0; rdy = 0; done_at = -1;
      bad = 0; first_en = -1; bi = 0; held = 8'h00;
      req_data0 = 8'hA5; req_last = 2'b00; req_valid = 2'b01;
      tick();
      tests++;
      if ({grant, busy, mod_rst_n, mod_enable, mod_data} !==
          {2'b01, 1'b1, 1'b0, 1'b0, 8'h55}) begin
         fails++;
         $display("FAIL sf_preload: grant=%b busy=%b rst_n=%b en=%b data=%h",
                  grant, busy, mod_rst_n, mod_enable, mod_data);
      end
      while (done_at < 0 && cyc < 1200) begin
         hs = req_ready[0] & req_valid[0];
         if (req_ready[0]) rdy++;
         tick(); cyc++;
         if (hs) begin
            bi++;
            if (bi == 1) begin
               req_data0 = 8'h3C; req_last = 2'b01;
            end else begin
               req_valid = 2'b00; req_last = 2'b00;
            end
         end
         if (mod_enable) begin
            if (first_en < 0) first_en = cyc;
            if (run == 0) begin
               held = mod_data;
               tests++;
               if (seg >= 4 || mod_data !== exp_seq[seg]) begin
                  fails++;
                  $display("FAIL sf_byte%0d: got %h want %h",
                           seg, mod_data, exp_seq[seg]);
               end
            end else if (mod_data !== held) begin
               bad++;
            end
            if (mod_rst_n !== 1'b1) bad++;
            run++;
         end else begin
            if (run != 0) begin
               tests++;
               if (run != 256) begin
                  fails++;
                  $display("FAIL sf_len%0d: got %0d want 256", seg, run);
               end
               seg++; run = 0;
            end
            if (mod_rst_n !== 1'b0) bad++;
         end
         if (frame_done) done_at = cyc;
      end
      tests++;
      if (first_en != 1) begin
         fails++;
         $display("FAIL sf_start: got %0d want 1", first_en);
      end
      tests++;
      if (done_at != 1028) begin
         fails++;
         $display("FAIL sf_done_at: got %0d want 1028", done_at);
      end
      tests++;
      if (seg != 4 || rdy != 2 || bad != 0) begin
         fails++;
         $display("FAIL sf_shape: segs=%0d rdy=%0d bad=%0d want 4/2/0",
                  seg, rdy, bad);
      end
      tests++;
      if ({grant, busy} !== 3'b000) begin
         fails++;
         $display("FAIL sf_done_grant: grant=%b busy=%b want 0", grant, busy);
      end
      tick();
      tests++;
      if ({frame_done, mod_enable} !== 2'b00) begin
         fails++;
         $display("FAIL sf_done_pulse: fd=%b en=%b want 0", frame_done, mod_enable);
      end
   endtask

   task automatic test_tie;
      logic [1:0] gseq [3];
      logic [1:0] prev;
      int ng, nd, bad, cyc;
      gseq = '{2'b00, 2'b00, 2'b00};
      ng = 0; nd = 0; bad = 0; cyc = 0; prev = 2'b00;
      rst_n = 1'b0;
      req_valid = 2'b11; req_last = 2'b11;
      req_data0 = 8'h11; req_data1 = 8'h22;
      tick();
      rst_n = 1'b1;
      while (nd < 3 && cyc < 3000) begin
         tick(); cyc++;
         if (grant != 2'b00 && prev == 2'b00 && ng < 3) begin
            gseq[ng] = grant; ng++;
         end
         prev = grant;
         if ((grant == 2'b01 && req_ready[1]) ||
             (grant == 2'b10 && req_ready[0])) bad++;
         if (frame_done) nd++;
      end
      req_valid = 2'b00; req_last = 2'b00;
      tick();
      tests++;
      if (gseq[0] !== 2'b01) begin
         fails++; $display("FAIL tie_g0: got %b want 01", gseq[0]);
      end
      tests++;
      if (gseq[1] !== 2'b10) begin
         fails++; $display("FAIL tie_g1: got %b want 10", gseq[1]);
      end
      tests++;
      if (gseq[2] !== 2'b01) begin
         fails++; $display("FAIL tie_g2: got %b want 01", gseq[2]);
      end
      tests++;
      if (nd != 3 || bad != 0) begin
         fails++;
         $display("FAIL tie_frames: done=%0d cross_ready=%0d want 3/0", nd, bad);
      end
   endtask

   task automatic test_underrun;
      logic hs;
      int cyc, bi, low, raised, run, maxrun, und, en_bad, done;
      cyc = 0; bi = 0; low = 0; raised = 0; run = 0;
      maxrun = 0; und = 0; en_bad = 0; done = 0;
      req_data1 = 8'hC3; req_last = 2'b00; req_valid = 2'b10;
      tick();
      tests++;
      if (grant !== 2'b10) begin
         fails++; $display("FAIL ur_grant: got %b want 10", grant);
      end
      while (done == 0 && cyc < 1500) begin
         hs = req_ready[1] & req_valid[1];
         if (req_ready[1]) begin
            run++;
            if (mod_enable) en_bad++;
            if (!req_valid[1]) low++;
         end else begin
            run = 0;
         end
         if (run > maxrun) maxrun = run;
         tick(); cyc++;
         if (hs) begin
            if (bi == 0) begin
               bi = 1; req_valid = 2'b00;
            end else begin
               req_valid = 2'b00; req_last = 2'b00;
            end
         end
         if (bi == 1 && low == 10 && raised == 0) begin
            raised = 1;
            req_valid = 2'b10; req_data1 = 8'h7E; req_last = 2'b10;
         end
         if (underrun) und++;
         if (frame_done) done = 1;
      end
      tests++;
      if (und != 1) begin
         fails++; $display("FAIL ur_pulses: got %0d want 1", und);
      end
      tests++;
      if (maxrun != 11) begin
         fails++; $display("FAIL ur_load_len: got %0d want 11", maxrun);
      end
      tests++;
      if (en_bad != 0 || done != 1) begin
         fails++;
         $display("FAIL ur_complete: en_in_load=%0d done=%0d want 0/1", en_bad, done);
      end
      tests++;
      if (mod_data !== 8'h7E) begin
         fails++; $display("FAIL ur_data: got %h want 7e", mod_data);
      end
      tick();
   endtask

   task automatic test_abort_and_reset;
      logic hs;
      int cyc, send, fired, bad;
      cyc = 0; send = -1; fired = 0; bad = 0;
      req_data0 = 8'h5A; req_last = 2'b00; req_valid = 2'b01;
      tick();
      while (fired == 0 && cyc < 1000) begin
         hs = req_ready[0] & req_valid[0];
         tick(); cyc++;
         if (hs) begin
            req_valid = 2'b00; send = 0;
         end else if (send >= 0) begin
            send++;
         end
         if (send == 100) begin
            fired = 1;
            tests++;
            if ({mod_enable, mod_data} !== {1'b1, 8'h5A}) begin
               fails++;
               $display("FAIL ab_pre: en=%b data=%h want 1/5a", mod_enable, mod_data);
            end
            abort = 1'b1;
         end
      end
      tick();
      abort = 1'b0;
      tests++;
      if ({mod_enable, mod_rst_n, grant, busy, frame_done} !== 6'b0) begin
         fails++;
         $display("FAIL ab_next: en=%b rst_n=%b grant=%b busy=%b fd=%b want 0",
                  mod_enable, mod_rst_n, grant, busy, frame_done);
      end
      for (int i = 0; i < 300; i++) begin
         tick();
         if (frame_done || mod_enable) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL ab_quiet: got %0d active cycles want 0", bad);
      end
      req_valid = 2'b11; req_last = 2'b11;
      req_data0 = 8'h44; req_data1 = 8'h66;
      tick();
      tests++;
      if (grant !== 2'b10) begin
         fails++; $display("FAIL ab_rearb: got %b want 10", grant);
      end
      tick(); tick();
      tests++;
      if ({mod_enable, mod_data} !== {1'b1, 8'h55}) begin
         fails++;
         $display("FAIL rm_presend: en=%b data=%h want 1/55", mod_enable, mod_data);
      end
      rst_n = 1'b0;
      #2;
      tests++;
      if ({mod_data, mod_enable, mod_rst_n, req_ready, grant,
           busy, frame_done, underrun} !== 17'h0) begin
         fails++;
         $display("FAIL rm_async: data=%h en=%b rst_n=%b rdy=%b grant=%b busy=%b",
                  mod_data, mod_enable, mod_rst_n, req_ready, grant, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tests++;
      if (grant !== 2'b01) begin
         fails++; $display("FAIL rm_tie: got %b want 01", grant);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      req_valid = 2'b00; req_last = 2'b00;
      tick();
   endtask

   task automatic test_no_preamble;
      logic hs;
      int cyc, en, done_at, bad;
      cyc = 0; en = 0; done_at = -1; bad = 0;
      b_data0 = 8'h9C; b_last = 2'b01; b_valid = 2'b01;
      tick();
      tests++;
      if ({b_ready, b_enable, b_rst_n, b_grant} !== {2'b01, 1'b0, 1'b0, 2'b01}) begin
         fails++;
         $display("FAIL np_load: rdy=%b en=%b rst_n=%b grant=%b",
                  b_ready, b_enable, b_rst_n, b_grant);
      end
      while (done_at < 0 && cyc < 100) begin
         hs = b_ready[0] & b_valid[0];
         tick(); cyc++;
         if (hs) begin
            b_valid = 2'b00; b_last = 2'b00;
         end
         if (b_enable) begin
            en++;
            if (b_mod_data !== 8'h9C) bad++;
         end
         if (b_frame_done) done_at = cyc;
      end
      tests++;
      if (en != 32 || bad != 0) begin
         fails++; $display("FAIL np_enabled: got %0d/%0d want 32/0", en, bad);
      end
      tests++;
      if (done_at != 33) begin
         fails++; $display("FAIL np_done_at: got %0d want 33", done_at);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_tie();
      test_underrun();
      test_abort_and_reset();
      test_no_preamble();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
